// File: rtl/grid_init_loader_pkg.sv
// Shared geometry, widths and types for the patch-array init path.
// The checksum width is only used when GRID_INIT_CHECKSUM_EN is defined.
package multpatch_pkg;
  localparam int PATCH_SIZE          = 4;
  localparam int PATCH_NUM_DIMENSION = 6;
  localparam int GRID_DIM            = PATCH_SIZE * PATCH_NUM_DIMENSION;
  localparam int PATCH_NUM           = PATCH_NUM_DIMENSION * PATCH_NUM_DIMENSION;
  localparam int DATA_W              = 18;
  localparam int PS_LOG2             = $clog2(PATCH_SIZE);
  localparam int COORD_W             = $clog2(GRID_DIM);
  localparam int PATCH_W             = 6;
  localparam int NODE_W              = 4;
  localparam int CSUM_W              = DATA_W + 10;

  typedef logic signed [DATA_W-1:0] node_t;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} loader_state_t;
endpackage

// File: rtl/grid_init_loader_if.sv
// Stream-in and patch-array write signals of the init loader.
// master = the loader, slave = the stream source / patch array side.
interface grid_init_loader_if;
  import multpatch_pkg::*;

  node_t               s_data;
  logic                s_valid;
  logic                s_ready;
  logic                w_en;
  logic [PATCH_W-1:0]  w_patch;
  logic [NODE_W-1:0]   w_node;
  node_t               w_data;
  logic                w_ready;

  modport master (
    input  s_data, s_valid, w_ready,
    output s_ready, w_en, w_patch, w_node, w_data
  );

  modport slave (
    output s_data, s_valid, w_ready,
    input  s_ready, w_en, w_patch, w_node, w_data
  );
endinterface

// File: rtl/grid_raster_counter.sv
// Raster (x,y) position over the grid with combinational patch/node mapping.
// Shared by the init loader and the readout serializer.
module grid_raster_counter
  import multpatch_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               advance_i,
  input  logic               clear_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               last_o,
  output logic [PATCH_W-1:0] patch_o,
  output logic [NODE_W-1:0]  node_o
);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_DIM - 1);

  logic [COORD_W-1:0] x_q, y_q;
  logic [PATCH_W-1:0] prow, pcol;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance_i) begin
      if (x_q == COORD_MAX) begin
        x_q <= '0;
        y_q <= (y_q == COORD_MAX) ? '0 : y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

  // Patch edge is a power of two, so patch coords are shifts and node coords are masks.
  assign prow    = PATCH_W'(y_q >> PS_LOG2);
  assign pcol    = PATCH_W'(x_q >> PS_LOG2);
  assign patch_o = PATCH_W'(prow * PATCH_NUM_DIMENSION) + pcol;
  assign node_o  = {y_q[PS_LOG2-1:0], x_q[PS_LOG2-1:0]};
  assign last_o  = (x_q == COORD_MAX) && (y_q == COORD_MAX);
  assign x_o     = x_q;
  assign y_o     = y_q;
endmodule

// File: rtl/grid_init_loader.sv
// Loads one raster frame into the patch array, then releases solver_enable.
// Optional GRID_INIT_CHECKSUM_EN adds a running signed checksum output.
module grid_init_loader
  import multpatch_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  grid_init_loader_if.master bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               solver_enable_o,
  output logic               overrun_o
`ifdef GRID_INIT_CHECKSUM_EN
  ,
  output logic signed [CSUM_W-1:0] checksum_o
`endif
);
  loader_state_t      state_q, state_d;
  logic               w_en_q, w_en_d;
  logic [PATCH_W-1:0] w_patch_q, w_patch_d;
  logic [NODE_W-1:0]  w_node_q, w_node_d;
  node_t              w_data_q, w_data_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;

  logic               s_ready, accept, wr_fire, start_ok, in_busy;
  logic               rc_last;
  logic [COORD_W-1:0] rc_x, rc_y;
  logic [PATCH_W-1:0] rc_patch;
  logic [NODE_W-1:0]  rc_node;

  assign in_busy  = (state_q == LOAD) || (state_q == DRAIN);
  assign s_ready  = (state_q == LOAD) && (!w_en_q || bus.w_ready);
  assign accept   = bus.s_valid && s_ready;
  assign wr_fire  = w_en_q && bus.w_ready;
  assign start_ok = start_i && !abort_i && !in_busy;

  grid_raster_counter u_raster (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .advance_i(accept && !abort_i),
    .clear_i  (abort_i || start_ok),
    .x_o      (rc_x),
    .y_o      (rc_y),
    .last_o   (rc_last),
    .patch_o  (rc_patch),
    .node_o   (rc_node)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      w_en_q    <= 1'b0;
      w_patch_q <= '0;
      w_node_q  <= '0;
      w_data_q  <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_en_q    <= w_en_d;
      w_patch_q <= w_patch_d;
      w_node_q  <= w_node_d;
      w_data_q  <= w_data_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_en_d    = w_en_q;
    w_patch_d = w_patch_q;
    w_node_d  = w_node_q;
    w_data_d  = w_data_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (abort_i) begin
      state_d = IDLE;
      w_en_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE:    if (start_i) state_d = LOAD;
        LOAD:    if (accept && rc_last) state_d = DRAIN;
        DRAIN:   if (wr_fire) begin
                   state_d = DONE;
                   done_d  = 1'b1;
                 end
        DONE:    if (start_i) state_d = LOAD;
        default: state_d = IDLE;
      endcase

      // A new beat may replace the outgoing write in the same cycle it is accepted.
      if (accept) begin
        w_en_d    = 1'b1;
        w_patch_d = rc_patch;
        w_node_d  = rc_node;
        w_data_d  = bus.s_data;
      end else if (wr_fire) begin
        w_en_d = 1'b0;
      end

      if (start_i) overrun_d = in_busy;
    end
  end

`ifdef GRID_INIT_CHECKSUM_EN
  logic signed [CSUM_W-1:0] checksum_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      checksum_q <= '0;
    end else if (abort_i || start_ok) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= checksum_q + CSUM_W'(bus.s_data);
    end
  end

  assign checksum_o = checksum_q;
`endif

  assign bus.s_ready      = s_ready;
  assign bus.w_en         = w_en_q;
  assign bus.w_patch      = w_patch_q;
  assign bus.w_node       = w_node_q;
  assign bus.w_data       = w_data_q;
  assign busy_o           = in_busy;
  assign done_o           = done_q;
  assign solver_enable_o  = (state_q == DONE);
  assign overrun_o        = overrun_q;

  // rc_x/rc_y are exposed by the counter for the serializer; unused here.
  logic unused_coords;
  assign unused_coords = ^{rc_x, rc_y};
endmodule

// File: tb/tb_grid_init_loader.sv
// Directed bench for grid_init_loader; checksum scenario built with GRID_INIT_CHECKSUM_EN.
module tb_grid_init_loader;
  import multpatch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, solver_enable, overrun;
`ifdef GRID_INIT_CHECKSUM_EN
  logic signed [CSUM_W-1:0] checksum;
`endif

  grid_init_loader_if bus();

  grid_init_loader dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .start_i        (start),
    .abort_i        (abort),
    .bus            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .solver_enable_o(solver_enable),
    .overrun_o      (overrun)
`ifdef GRID_INIT_CHECKSUM_EN
    ,
    .checksum_o     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write monitor: records every accepted write by (patch,node) and counts done pulses.
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   wr_hits [PATCH_NUM][16];
  int   wr_val  [PATCH_NUM][16];
  logic sb_clear = 1'b0;

  always @(posedge clk) begin
    if (sb_clear) begin
      wr_cnt   <= 0;
      done_cnt <= 0;
      for (int p = 0; p < PATCH_NUM; p++)
        for (int n = 0; n < 16; n++) begin
          wr_hits[p][n] <= 0;
          wr_val[p][n]  <= 0;
        end
    end else begin
      if (bus.w_en === 1'b1 && bus.w_ready === 1'b1) begin
        wr_cnt <= wr_cnt + 1;
        wr_hits[bus.w_patch][bus.w_node] <= wr_hits[bus.w_patch][bus.w_node] + 1;
        wr_val[bus.w_patch][bus.w_node]  <= int'(bus.w_data);
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
    end
  end

  function automatic node_t beat_val(input int mode, input int base, input int idx);
    case (mode)
      1:       return (idx % 2 == 0) ? -18'sd1 : 18'sd2;
      2:       return 18'(-idx - 1);
      default: return 18'(base + idx);
    endcase
  endfunction

  function automatic logic stall_pat(input int cyc);
    return (cyc % 4 == 0) || (cyc % 4 == 3);
  endfunction

  task automatic clear_sb;
    @(negedge clk); sb_clear = 1'b1;
    @(negedge clk); sb_clear = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
  endtask

  task automatic pulse_abort;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1;
  endtask

  // Streams n beats with w_ready=1; returns just after the edge that took the last beat.
  task automatic feed(input int n, input int mode, input int base, output int cycles);
    int idx = 0;
    cycles = 0;
    while (idx < n && cycles < n * 4 + 100) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = beat_val(mode, base, idx);
      bus.w_ready = 1'b1;
      #1;
      if (bus.s_ready === 1'b1) idx++;
      cycles++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    #1;
  endtask

  function automatic logic [36:0] out_vec();
    return {bus.s_ready, bus.w_en, bus.w_patch, bus.w_node, bus.w_data,
            busy, done, solver_enable, overrun};
  endfunction

  task automatic test_reset;
    int cyc;
    logic [36:0] v;
    #2;
    @(negedge clk); #1;
    v = out_vec();
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", v); end
    rst = 1'b0;
    $display("reset: initial outputs %h", v);

    clear_sb();
    pulse_start();
    feed(100, 0, 1000, cyc);
    rst = 1'b1;
    @(negedge clk); #1;
    v = out_vec();
    n_checks++;
    if (v !== '0) begin n_fail++; $display("FAIL midload_reset_outputs: got %h expected 0", v); end
    rst = 1'b0;
    pulse_start();
    feed(1, 0, 7, cyc);
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.w_patch !== 6'd0 || bus.w_node !== 4'd0 || bus.w_data !== 18'sd7) begin
      n_fail++;
      $display("FAIL reload_first_beat: got en=%0b p=%0d n=%0d d=%0d expected en=1 p=0 n=0 d=7",
               bus.w_en, bus.w_patch, bus.w_node, bus.w_data);
    end
    $display("reset: mid-load reset then reload p=%0d n=%0d d=%0d", bus.w_patch, bus.w_node, bus.w_data);
    pulse_abort();
  endtask

  task automatic test_full_frame;
    int cyc, errs;
    clear_sb();
    pulse_start();
    feed(GRID_DIM * GRID_DIM, 0, 0, cyc);
    n_checks++;
    if (cyc !== 576) begin n_fail++; $display("FAIL frame_cycles: got %0d expected 576", cyc); end
    n_checks++;
    if (bus.w_en !== 1'b1 || bus.w_patch !== 6'd35 || bus.w_node !== 4'd15 || bus.w_data !== 18'sd575) begin
      n_fail++;
      $display("FAIL last_write: got en=%0b p=%0d n=%0d d=%0d expected en=1 p=35 n=15 d=575",
               bus.w_en, bus.w_patch, bus.w_node, bus.w_data);
    end
    n_checks++;
    if (bus.s_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_state: got rdy=%0b busy=%0b done=%0b expected 0 1 0", bus.s_ready, busy, done);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || solver_enable !== 1'b1 || busy !== 1'b0 || bus.w_en !== 1'b0) begin
      n_fail++;
      $display("FAIL done_entry: got done=%0b se=%0b busy=%0b en=%0b expected 1 1 0 0",
               done, solver_enable, busy, bus.w_en);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || solver_enable !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse_width: got done=%0b se=%0b expected 0 1", done, solver_enable);
    end
    n_checks++;
    if (wr_cnt !== 576 || done_cnt !== 1) begin
      n_fail++; $display("FAIL frame_counts: got writes=%0d dones=%0d expected 576 1", wr_cnt, done_cnt);
    end
    n_checks++;
    if (wr_val[0][5] !== 25 || wr_val[7][0] !== 100 || wr_val[35][15] !== 575) begin
      n_fail++;
      $display("FAIL spot_map: got %0d %0d %0d expected 25 100 575", wr_val[0][5], wr_val[7][0], wr_val[35][15]);
    end
    errs = 0;
    for (int y = 0; y < GRID_DIM; y++)
      for (int x = 0; x < GRID_DIM; x++) begin
        int p = (y / 4) * 6 + x / 4;
        int n = (y % 4) * 4 + x % 4;
        n_checks++;
        if (wr_hits[p][n] !== 1 || wr_val[p][n] !== y * 24 + x) begin
          n_fail++; errs++;
          $display("FAIL frame_map x=%0d y=%0d: got hits=%0d val=%0d expected 1 %0d",
                   x, y, wr_hits[p][n], wr_val[p][n], y * 24 + x);
        end
      end
    $display("full_frame: %0d writes in %0d cycles, %0d map errors", wr_cnt, cyc, errs);
  endtask

  task automatic test_stall;
    int idx = 0, cyc = 0, errs = 0;
    logic prev_stall = 1'b0, seen = 1'b0;
    node_t prev_data = '0;
    clear_sb();
    pulse_start();
    while (cyc < 3000 && !seen) begin
      @(negedge clk);
      bus.s_valid = (idx < 576);
      bus.s_data  = beat_val(2, 0, idx);
      bus.w_ready = stall_pat(cyc);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (bus.w_en !== 1'b1 || bus.w_data !== prev_data) begin
          n_fail++; $display("FAIL stall_hold cyc=%0d: got en=%0b d=%0d expected 1 %0d", cyc, bus.w_en, bus.w_data, prev_data);
        end
      end
      if (bus.w_en === 1'b1 && bus.w_ready === 1'b0) begin
        n_checks++;
        if (bus.s_ready !== 1'b0) begin
          n_fail++; $display("FAIL stall_sready cyc=%0d: got %0b expected 0", cyc, bus.s_ready);
        end
      end
      prev_stall = (bus.w_en === 1'b1) && (bus.w_ready === 1'b0);
      prev_data  = bus.w_data;
      if (bus.s_valid && bus.s_ready === 1'b1) idx++;
      if (done === 1'b1) seen = 1'b1;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.w_ready = 1'b1;
    n_checks++;
    if (!seen || solver_enable !== 1'b1) begin
      n_fail++; $display("FAIL stall_done: got seen=%0b se=%0b expected 1 1", seen, solver_enable);
    end
    @(negedge clk); #1;
    n_checks++;
    if (wr_cnt !== 576 || done_cnt !== 1) begin
      n_fail++; $display("FAIL stall_counts: got writes=%0d dones=%0d expected 576 1", wr_cnt, done_cnt);
    end
    for (int y = 0; y < GRID_DIM; y++)
      for (int x = 0; x < GRID_DIM; x++) begin
        int p = (y / 4) * 6 + x / 4;
        int n = (y % 4) * 4 + x % 4;
        n_checks++;
        if (wr_hits[p][n] !== 1 || wr_val[p][n] !== -(y * 24 + x) - 1) begin
          n_fail++; errs++;
          $display("FAIL stall_map x=%0d y=%0d: got hits=%0d val=%0d expected 1 %0d",
                   x, y, wr_hits[p][n], wr_val[p][n], -(y * 24 + x) - 1);
        end
      end
    $display("stall: %0d writes over %0d cycles, %0d map errors", wr_cnt, cyc, errs);
  endtask

  task automatic test_overrun;
    int idx = 0, cyc = 0;
    clear_sb();
    pulse_start();
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear_start: got %0b expected 0", overrun); end
    while (idx < 576 && cyc < 2000) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = beat_val(0, 0, idx);
      bus.w_ready = 1'b1;
      start       = (idx == 300);
      #1;
      if (bus.s_ready === 1'b1) idx++;
      cyc++;
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    start = 1'b0;
    #1;
    n_checks++;
    if (overrun !== 1'b1 || busy !== 1'b1 || cyc !== 576) begin
      n_fail++; $display("FAIL overrun_set: got ovr=%0b busy=%0b cyc=%0d expected 1 1 576", overrun, busy, cyc);
    end
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || overrun !== 1'b1 || solver_enable !== 1'b1) begin
      n_fail++; $display("FAIL overrun_done: got done=%0b ovr=%0b se=%0b expected 1 1 1", done, overrun, solver_enable);
    end
    @(negedge clk); #1;
    n_checks++;
    if (wr_cnt !== 576) begin n_fail++; $display("FAIL overrun_writes: got %0d expected 576", wr_cnt); end
    pulse_start();
    n_checks++;
    if (overrun !== 1'b0 || solver_enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_from_done: got ovr=%0b se=%0b busy=%0b expected 0 0 1", overrun, solver_enable, busy);
    end
    $display("overrun: set during load, cleared by start in DONE, writes=%0d", wr_cnt);
  endtask

  task automatic test_abort_start;
    int cyc;
    pulse_abort();
    clear_sb();
    pulse_start();
    feed(50, 0, 5000, cyc);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.w_en !== 1'b0 || solver_enable !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wins: got busy=%0b rdy=%0b en=%0b se=%0b ovr=%0b expected all 0",
               busy, bus.s_ready, bus.w_en, solver_enable, overrun);
    end
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done_cnt !== 0 || wr_cnt !== 50) begin
      n_fail++; $display("FAIL abort_idle: got busy=%0b dones=%0d writes=%0d expected 0 0 50", busy, done_cnt, wr_cnt);
    end
    pulse_start();
    feed(1, 0, 42, cyc);
    n_checks++;
    if (bus.w_patch !== 6'd0 || bus.w_node !== 4'd0 || bus.w_data !== 18'sd42) begin
      n_fail++; $display("FAIL abort_counters_zeroed: got p=%0d n=%0d d=%0d expected 0 0 42", bus.w_patch, bus.w_node, bus.w_data);
    end
    $display("abort_start: idle after abort, writes=%0d dones=%0d", wr_cnt, done_cnt);
  endtask

`ifdef GRID_INIT_CHECKSUM_EN
  task automatic test_checksum;
    int cyc;
    pulse_abort();
    pulse_start();
    n_checks++;
    if (checksum !== '0) begin n_fail++; $display("FAIL checksum_zeroed: got %0d expected 0", checksum); end
    feed(576, 1, 0, cyc);
    @(negedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || checksum !== 28'sd288) begin
      n_fail++; $display("FAIL checksum_at_done: got done=%0b sum=%0d expected 1 288", done, checksum);
    end
    @(negedge clk); #1;
    n_checks++;
    if (checksum !== 28'sd288) begin n_fail++; $display("FAIL checksum_stable: got %0d expected 288", checksum); end
    $display("checksum: %0d after full frame", checksum);
  endtask
`endif

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.w_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_stall();
    test_overrun();
    test_abort_start();
`ifdef GRID_INIT_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
